// File: rtl/seg7_capture.sv
// Captures a multiplexed 4-digit seven-segment bus into hex nibbles once each pattern is stable.
// Optional: define SEG7_CAPTURE_ERR_CNT_EN to add the saturating err_cnt output.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  valid,
  output logic [3:0]  blank,
  output logic        upd,
  output logic        err,
  output logic        frame
`ifdef SEG7_CAPTURE_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  logic [10:0] r_samp;
  logic [7:0]  r_cnt;
  logic [15:0] r_value;
  logic [3:0]  r_valid;
  logic [3:0]  r_blank;
  logic [3:0]  r_seen;
  logic        r_upd;
  logic        r_err;
  logic        r_frame;

  logic        w_onehot;
  logic        w_stable;
  logic        w_capture;
  logic        w_known;
  logic        w_blankpat;
  logic [3:0]  w_nib;
  logic [1:0]  w_dig;
  logic [3:0]  w_seen_nxt;

  always_comb begin
    w_known = 1'b1;
    w_nib   = '0;
    case (seg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_known = 1'b0;
    endcase
  end

  always_comb begin
    w_dig = 2'd0;
    case (an)
      4'b0010: w_dig = 2'd1;
      4'b0100: w_dig = 2'd2;
      4'b1000: w_dig = 2'd3;
      default: w_dig = 2'd0;
    endcase
  end

  assign w_blankpat = (seg == 7'h00);
  assign w_onehot   = (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
  assign w_stable   = w_onehot && ({an, seg} == r_samp);
  // Capture fires only on the step into saturation, so a held pattern is taken once.
  assign w_capture  = w_stable && (r_cnt == LP_STABLE - 8'd1);
  assign w_seen_nxt = r_seen | an;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp  <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_valid <= '0;
      r_blank <= '0;
      r_seen  <= '0;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_samp  <= {an, seg};
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= 1'b0;
      if (!w_stable)
        r_cnt <= '0;
      else if (r_cnt != LP_STABLE)
        r_cnt <= r_cnt + 8'd1;
      if (w_capture) begin
        if (w_known || w_blankpat) begin
          r_value[{w_dig, 2'b00} +: 4] <= w_nib;
          r_valid[w_dig]               <= w_known;
          r_blank[w_dig]               <= ~w_known;
          r_upd                        <= 1'b1;
          if (w_seen_nxt == 4'hF) begin
            r_frame <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen  <= w_seen_nxt;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign value = r_value;
  assign valid = r_valid;
  assign blank = r_blank;
  assign upd   = r_upd;
  assign err   = r_err;
  assign frame = r_frame;

`ifdef SEG7_CAPTURE_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_err_cnt <= '0;
    else if (w_capture && !w_known && !w_blankpat && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized self-checking bench for seg7_capture against a history-based reference model.
module tb_seg7_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic        upd;
  logic        err;
  logic        frame;
`ifdef SEG7_CAPTURE_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst   (rst),
    .seg   (seg),
    .an    (an),
    .value (value),
    .valid (valid),
    .blank (blank),
    .upd   (upd),
    .err   (err),
    .frame (frame)
`ifdef SEG7_CAPTURE_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: per-digit contents, which digits were seen, and the recent input history.
  int   hist[$];
  int   m_nib[4];
  bit   m_valid[4];
  bit   m_blank[4];
  bit   m_seen[4];
  bit   m_upd, m_err, m_frame;
  int   m_ecnt;
  int   frames_seen, errs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    hist.push_back(-1);
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 0; m_valid[i] = 0; m_blank[i] = 0; m_seen[i] = 0;
    end
    m_upd = 0; m_err = 0; m_frame = 0; m_ecnt = 0;
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 16; k++)
      if (pat[k] == s) return k;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    int  x, d, n;
    bit  cap, all4;
    m_upd = 0; m_err = 0; m_frame = 0;
    x = ($countones(a) == 1) ? int'({a, s}) : -1;
    hist.push_back(x);
    while (hist.size() > S + 2) void'(hist.pop_front());
    // A capture needs S+1 consecutive identical one-hot inputs with a different one before them.
    cap = (x >= 0) && (hist.size() == S + 2) && (hist[0] != x);
    for (int k = 1; k < S + 2; k++)
      if (hist.size() == S + 2 && hist[k] != x) cap = 0;
    if (!cap) return;
    d = 0;
    for (int k = 0; k < 4; k++) if (a[k]) d = k;
    n = lookup(s);
    if (n >= 0 || s == 7'h00) begin
      m_nib[d] = (n >= 0) ? n : 0;
      m_valid[d] = (n >= 0);
      m_blank[d] = (n < 0);
      m_upd = 1;
      m_seen[d] = 1;
      all4 = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
      if (all4) begin
        m_frame = 1;
        for (int k = 0; k < 4; k++) m_seen[k] = 0;
      end
    end else begin
      m_err = 1;
      if (m_ecnt < 255) m_ecnt++;
    end
  endtask

  task automatic tick(input logic [3:0] a, input logic [6:0] s, input logic r);
    logic [15:0] ev;
    logic [3:0]  evd, ebl;
    an = a; seg = s; rst = r;
    @(posedge clk);
    if (r) model_reset(); else model_edge(a, s);
    #1;
    for (int i = 0; i < 4; i++) begin
      ev[4*i +: 4] = 4'(m_nib[i]);
      evd[i] = m_valid[i];
      ebl[i] = m_blank[i];
    end
    check("value", 32'(value), 32'(ev));
    check("valid", 32'(valid), 32'(evd));
    check("blank", 32'(blank), 32'(ebl));
    check("upd",   32'(upd),   32'(m_upd));
    check("err",   32'(err),   32'(m_err));
    check("frame", 32'(frame), 32'(m_frame));
`ifdef SEG7_CAPTURE_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
    if (frame) frames_seen++;
    if (err) errs_seen++;
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int cycles);
    for (int c = 0; c < cycles; c++) tick(a, s, 1'b0);
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         sel;
    an = '0; seg = '0; rst = 1'b1;
    model_reset();
    #2;
    tick(4'b0000, 7'h00, 1'b1);
    tick(4'b0000, 7'h00, 1'b1);

    // Single digit, first capture on edge S+1.
    hold(4'b0001, 7'h4F, 6);
    check("dig0_is_3", 32'(value[3:0]), 32'h3);
    check("valid_0001", 32'(valid), 32'h1);

    // Short unstable pattern is skipped, the following one is captured.
    tick(4'b0000, 7'h00, 1'b1);
    hold(4'b0010, 7'h7C, 3);
    hold(4'b0010, 7'h06, 5);
    check("dig1_is_1", 32'(value[7:4]), 32'h1);

    // Full scan produces one frame.
    tick(4'b0000, 7'h00, 1'b1);
    frames_seen = 0;
    hold(4'b0001, 7'h6D, 6);
    hold(4'b0010, 7'h00, 6);
    hold(4'b0100, 7'h77, 6);
    hold(4'b1000, 7'h3F, 6);
    check("scan_value", 32'(value), 32'h0A05);
    check("scan_valid", 32'(valid), 32'hD);
    check("scan_blank", 32'(blank), 32'h2);
    check("scan_frames", 32'(frames_seen), 32'd1);

    // Undecodable pattern: one err pulse, nothing else moves.
    errs_seen = 0; frames_seen = 0;
    hold(4'b0100, 7'h7E, 8);
    check("bad_errs", 32'(errs_seen), 32'd1);
    check("bad_value", 32'(value), 32'h0A05);
    check("bad_frames", 32'(frames_seen), 32'd0);
`ifdef SEG7_CAPTURE_ERR_CNT_EN
    check("bad_errcnt", 32'(err_cnt), 32'd1);
`endif

    // Multi-hot enables do nothing; reset mid-window restarts the window.
    hold(4'b0011, 7'h3F, 10);
    hold(4'b0001, 7'h5B, 3);
    tick(4'b0001, 7'h5B, 1'b1);
    check("rst_value", 32'(value), 32'h0);
    hold(4'b0001, 7'h5B, 4);
    check("rst_no_early", 32'(valid), 32'h0);
    hold(4'b0001, 7'h5B, 1);
    check("rst_capture", 32'(value[3:0]), 32'h2);

    // Random holds mixing good, blank, bad patterns, bad enables and resets.
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      a = 4'b0001 << $urandom_range(0, 3);
      if (sel == 0) a = 4'($urandom_range(0, 15));
      s = pat[$urandom_range(0, 15)];
      if (sel == 1) s = 7'h00;
      if (sel == 2) s = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 40) == 0)
        tick(a, s, 1'b1);
      hold(a, s, $urandom_range(1, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
